bloom_filter_engine: RTL
========================

# bloom_filter_engine

Parametrised Bloom-filter engine with insert and membership-query operations, a valid/ready command and response interface, and a hardware clear. It generalises the team's fixed 7-hash, 72-bit-key insert-only filter. The engine owns its bit array as an internal word-organised synchronous RAM and performs per-hash read-modify-write. It sits between the packet-key extractor (command side) and the lookup consumer (response side).

## Interface
- KEY_W, default 72: key width in bits; must be a multiple of 8.
- NUM_HASH, default 7: hash functions per key; range 1..16.
- ADDR_W, default 11: bit-index width; the bit array holds 2^ADDR_W bits.
- WORD_W, default 32: RAM word width; power of two, at most 2^ADDR_W. DEPTH = 2^ADDR_W / WORD_W words.
- CNT_W, default 16: element-counter width.

Ports:
- clka  in  1  clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine accepts a command.
- cmd_op  in  1  0 = insert, 1 = query.
- cmd_key  in  KEY_W  key.
- clear_req  in  1  request a full-array clear.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_op  out  1  op of the completed command.
- rsp_hit  out  1  query: all NUM_HASH bits were set. Insert: all bits were already set before the insert.
- clear_busy  out  1  a clear sweep is in progress.
- elem_count  out  CNT_W  count of inserts with rsp_hit=0; saturates at all-ones.

## Operation
- Hash k (k = 0..NUM_HASH-1), all arithmetic 32-bit modulo 2^32:
  - Seed: h = 32'hDEADBEEF + k*32'h9E3779B9.
  - For byte i = 0..KEY_W/8-1, with byte i = cmd_key[8i+7:8i]: h += byte; h += h<<10; h ^= h>>6.
  - Then: h += h<<3; h ^= h>>11; h += h<<15.
  - idx_k = h[ADDR_W-1:0].
- Addressing: word address = idx_k[ADDR_W-1:log2(WORD_W)]; bit position = idx_k[log2(WORD_W)-1:0].
- States: CLEAR, IDLE, HASH, READ, CHECK, RESP.
  - CLEAR: writes zero to word wptr each cycle, with wptr counting 0..DEPTH-1. After the last word, go to IDLE. Also zeroes elem_count.
  - IDLE: cmd_ready = !clear_req.
    - If clear_req: go to CLEAR. clear_req wins over a simultaneous cmd_valid, and that command is not accepted.
    - Else if cmd_valid: latch the key and op, go to HASH.
    - clear_req outside IDLE is ignored. It is a level; the requester holds it until clear_busy is seen.
  - HASH: register all NUM_HASH indices (1 cycle); k = 0; go to READ.
  - READ: issue a RAM read of the word for idx_k; go to CHECK.
  - CHECK: word data is valid; b = the selected bit; hit accumulates as hit &= b.
    - Insert: write the word back with the bit set (written even if it was already set).
    - Query with b = 0: hit = 0; go to RESP immediately (early exit).
    - Otherwise: if k = NUM_HASH-1, go to RESP; else k++ and go to READ.
  - RESP: rsp_valid = 1, rsp_hit and rsp_op held stable until rsp_ready. On the handshake go to IDLE. An insert with hit = 0 increments elem_count on that handshake edge.
- RAM hazard: the CHECK write lands on the edge before the next READ. A later hash of the same key that maps to the same word sees the updated data, so no bypass logic is needed.
- rsp_hit semantics: a false positive is allowed; a false negative is never allowed.

## Timing
- Reset value of every output:
  - cmd_ready 0, rsp_valid 0, rsp_hit 0, rsp_op 0, elem_count 0, clear_busy 1.
  - The FSM resets into CLEAR with wptr = 0. RAM contents are not reset; the automatic sweep defines them.
- Reset deassert to first cmd_ready = 1: DEPTH cycles. clear_busy is high for exactly those cycles.
- Cycle numbering below: cycle 0 is the cycle in which the command handshake occurs.
- Insert, or a query that hits: rsp_valid first high in cycle 2*NUM_HASH+2 (16 at defaults).
- Query whose first zero bit is at hash j: rsp_valid first high in cycle 2j+4.
- Throughput: one command in flight. cmd_ready is 0 from cycle 1 until the cycle after the response handshake.
- Response handshake: if rsp_ready is already high when rsp_valid rises, the handshake completes in that cycle.
- Clear: DEPTH cycles starting the cycle after clear_req is taken in IDLE.
- Reset mid-operation: the command is dropped, no response is produced, and a full clear runs. The elem_count saturation boundary holds at all-ones.

## Test plan
- Reset release -> clear_busy high for exactly 64 cycles, cmd_ready 0 during the sweep, then cmd_ready 1 and elem_count 0.
- Query key 72'h0 on the empty array -> rsp_valid in cycle 4, rsp_hit 0, rsp_op 1.
- Insert key 72'h0123456789ABCDEF01 -> rsp_valid in cycle 16, rsp_hit 0, elem_count 1.
  - Query the same key -> rsp_hit 1 in cycle 16.
  - Insert it again -> rsp_hit 1, elem_count stays 1.
- Backpressure: hold rsp_ready low for 5 cycles after rsp_valid -> rsp_valid, rsp_hit and rsp_op stable, cmd_ready 0. One response is delivered when rsp_ready rises.
- Assert clear_req and cmd_valid together in IDLE -> command not accepted, 64-cycle clear. A following query of the earlier key gives rsp_hit 0 and elem_count 0.
- Pulse rst_n low during the CHECK state of an insert -> no response, a 64-cycle clear, and a following query of that key gives rsp_hit 0.
- Additionally run with NUM_HASH=3, WORD_W=64 against a bit-exact reference model: 200 random inserts and queries, all inserted keys hit, and response latency matches the formulas above.

Source files
------------

// File: rtl/bloom_filter_engine.sv
`default_nettype none
// ============================================================================
// Module   : bloom_filter_engine
// Brief    : Bloom filter with insert/query over an internal word-organised
//            synchronous RAM, valid/ready command and response, hardware clear.
// Revision : 1.0 - initial release
// ============================================================================
module bloom_filter_engine #(
   parameter int KEY_W    = 72,
   parameter int NUM_HASH = 7,
   parameter int ADDR_W   = 11,
   parameter int WORD_W   = 32,
   parameter int CNT_W    = 16
) (
   input  logic             clka,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_op,
   input  logic [KEY_W-1:0] cmd_key,
   input  logic             clear_req,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_op,
   output logic             rsp_hit,
   output logic             clear_busy,
   output logic [CNT_W-1:0] elem_count
);

   localparam int BIT_W = $clog2(WORD_W);
   localparam int WA_W  = (ADDR_W > BIT_W) ? (ADDR_W - BIT_W) : 1;
   localparam int DEPTH = (1 << ADDR_W) / WORD_W;
   localparam int K_W   = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;
   localparam int NBYTE = KEY_W / 8;

   typedef enum logic [2:0] {
      S_CLEAR = 3'd0,
      S_IDLE  = 3'd1,
      S_HASH  = 3'd2,
      S_READ  = 3'd3,
      S_CHECK = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [KEY_W-1:0]  r_key;
   logic              r_op;
   logic              r_hit;
   logic [K_W-1:0]    r_k;
   logic [WA_W-1:0]   r_wptr;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_idx  [NUM_HASH];
   logic [ADDR_W-1:0] w_hash [NUM_HASH];

   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] r_rdata;

   logic [ADDR_W-1:0] w_cur_idx;
   logic [WA_W-1:0]   w_waddr;
   logic [BIT_W-1:0]  w_bitpos;
   logic              w_bit;
   logic              w_we;
   logic              w_re;
   logic [WA_W-1:0]   w_ram_addr;
   logic [WORD_W-1:0] w_wdata;

   // One-at-a-time style mixing with a per-hash seed; 32-bit wrap-around arithmetic.
   function automatic logic [ADDR_W-1:0] hash_idx(input logic [KEY_W-1:0] key, input int k);
      logic [31:0] h;
      logic [31:0] kk;
      kk = 32'(k);
      h  = 32'hDEADBEEF + kk * 32'h9E3779B9;
      for (int i = 0; i < NBYTE; i++) begin
         h = h + {24'h0, key[8*i +: 8]};
         h = h + (h << 10);
         h = h ^ (h >> 6);
      end
      h = h + (h << 3);
      h = h ^ (h >> 11);
      h = h + (h << 15);
      return h[ADDR_W-1:0];
   endfunction

   for (genvar g = 0; g < NUM_HASH; g++) begin : g_hash
      assign w_hash[g] = hash_idx(r_key, g);
   end

   assign w_cur_idx = r_idx[r_k];
   assign w_bitpos  = w_cur_idx[BIT_W-1:0];
   assign w_bit     = r_rdata[w_bitpos];

   if (ADDR_W > BIT_W) begin : g_waddr
      assign w_waddr = w_cur_idx[ADDR_W-1:BIT_W];
   end else begin : g_waddr_single
      assign w_waddr = '0;
   end

   assign w_we       = (r_state == S_CLEAR) || ((r_state == S_CHECK) && !r_op);
   assign w_re       = (r_state == S_READ);
   assign w_ram_addr = (r_state == S_CLEAR) ? r_wptr : w_waddr;
   assign w_wdata    = (r_state == S_CLEAR) ? '0 : (r_rdata | (WORD_W'(1) << w_bitpos));

   // Read-before-next-read ordering: a CHECK write lands before the following READ.
   always_ff @(posedge clka) begin
      if (w_we) begin
         mem[w_ram_addr] <= w_wdata;
      end
      if (w_re) begin
         r_rdata <= mem[w_waddr];
      end
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_CLEAR;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      cmd_ready  = 1'b0;
      rsp_valid  = 1'b0;
      clear_busy = 1'b0;
      case (r_state)
         S_CLEAR: begin
            clear_busy = 1'b1;
            if (r_wptr == WA_W'(DEPTH - 1)) begin
               w_next = S_IDLE;
            end
         end
         S_IDLE: begin
            cmd_ready = !clear_req;
            if (clear_req) begin
               w_next = S_CLEAR;
            end else if (cmd_valid) begin
               w_next = S_HASH;
            end
         end
         S_HASH:  w_next = S_READ;
         S_READ:  w_next = S_CHECK;
         S_CHECK: begin
            if (r_op && !w_bit) begin
               w_next = S_RESP;
            end else if (r_k == K_W'(NUM_HASH - 1)) begin
               w_next = S_RESP;
            end else begin
               w_next = S_READ;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_CLEAR;
      endcase
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         r_key   <= '0;
         r_op    <= 1'b0;
         r_hit   <= 1'b0;
         r_k     <= '0;
         r_wptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < NUM_HASH; i++) begin
            r_idx[i] <= '0;
         end
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_wptr  <= r_wptr + 1'b1;
               r_count <= '0;
            end
            S_IDLE: begin
               r_wptr <= '0;
               if (!clear_req && cmd_valid) begin
                  r_key <= cmd_key;
                  r_op  <= cmd_op;
               end
            end
            S_HASH: begin
               r_idx <= w_hash;
               r_hit <= 1'b1;
               r_k   <= '0;
            end
            S_CHECK: begin
               r_hit <= r_hit & w_bit;
               if (!(r_op && !w_bit) && (r_k != K_W'(NUM_HASH - 1))) begin
                  r_k <= r_k + 1'b1;
               end
            end
            S_RESP: begin
               // Only genuinely new elements are counted; saturate rather than wrap.
               if (rsp_ready && !r_op && !r_hit && (r_count != '1)) begin
                  r_count <= r_count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_hit    = r_hit;
   assign rsp_op     = r_op;
   assign elem_count = r_count;

endmodule
`default_nettype wire
